mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 45 ++++
 rtl/mem_responder_lane_align.sv | 51 +++++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared defines for the memory responder: instruction opcodes
//                and RISC-V funct3 access-size codes, plus a request legality
//                helper used by the responder top.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Major opcodes of the instructions that generate memory requests
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // funct3 access-size codes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Returns 1 when a request must be rejected: misaligned, unknown size,
    // unsigned store, or a word index beyond the storage (no wrap-around).
    function automatic logic req_is_err(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [2:0]  size,
                                        input logic [31:0] depth);
        logic e;
        case (size)
            SZ_B, SZ_BU: e = 1'b0;
            SZ_H, SZ_HU: e = addr[0];
            SZ_W:        e = |addr[1:0];
            default:     e = 1'b1;
        endcase
        if (we && ((size == SZ_BU) || (size == SZ_HU))) begin
            e = 1'b1;
        end
        if ({2'b00, addr[31:2]} >= depth) begin
            e = 1'b1;
        end
        return e;
    endfunction

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane logic shared by the load and store
//                paths: extracts/extends load data from a word and merges
//                store data into the addressed lanes of a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign rhalf = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Load path: pick the lane(s) and sign- or zero-extend by size code
    always_comb begin
        load_o = 32'h0;
        case (size_i)
            SZ_B:    load_o = {{24{rbyte[7]}}, rbyte};
            SZ_BU:   load_o = {24'h0, rbyte};
            SZ_H:    load_o = {{16{rhalf[15]}}, rhalf};
            SZ_HU:   load_o = {16'h0, rhalf};
            SZ_W:    load_o = rword_i;
            default: load_o = 32'h0;
        endcase
    end

    // Store path: replace only the addressed lanes, keep the rest of the word
    always_comb begin
        merged_o = rword_i;
        case (size_i)
            SZ_B:    merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_H:    merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_W:    merged_o = wdata_i;
            default: merged_o = rword_i;
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Single-outstanding memory slave with word storage, a
//                programmable number of wait states and byte/half/word
//                access with alignment and range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        in_idle, commit;
    logic        op_we, op_err;
    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_size;
    logic [IDX_W-1:0] op_idx;
    logic [31:0] rd_word, load_data, merged_word;

    // With zero wait states the response is committed on the accepting edge,
    // before the capture registers hold the request, so use the live inputs.
    assign in_idle  = (state_q == S_IDLE);
    assign op_we    = in_idle ? req_we    : we_q;
    assign op_addr  = in_idle ? req_addr  : addr_q;
    assign op_wdata = in_idle ? req_wdata : wdata_q;
    assign op_size  = in_idle ? req_size  : size_q;
    assign op_err   = req_is_err(op_we, op_addr, op_size, DEPTH_L);
    assign op_idx   = op_addr[IDX_W+1:2];
    assign rd_word  = mem_q[op_idx];
    assign commit   = (state_d == S_RESP) && (state_q != S_RESP);

    mem_lane_align u_lane_align (
        .size_i    (op_size),
        .addr_lo_i (op_addr[1:0]),
        .rword_i   (rd_word),
        .wdata_i   (op_wdata),
        .load_o    (load_data),
        .merged_o  (merged_word)
    );

    // Next-state, wait counter and response data
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = op_err;
            rdata_d = (op_err || op_we) ? 32'h0 : load_data;
        end
    end

    // State, counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request capture on acceptance; inputs are ignored in any other cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'b000;
        end else if (in_idle && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
        end
    end

    // Storage is never reset; a reset coincident with the commit edge drops the store
    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err && !rst) begin
            mem_q[op_idx] <= merged_word;
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder: directed vectors,
//                reset behaviour, back-to-back throughput with zero wait
//                states, and random traffic against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // DUT with WAIT_CYCLES = 2
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    // DUT with WAIT_CYCLES = 0
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [2:0]  b_req_size;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned ref_mem [4*DEPTH];

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    // Reference model: byte-addressed little-endian memory
    task automatic model_op(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] size,
                            output logic [31:0] exp_rdata, output logic exp_err);
        int nb;
        logic [31:0] v;
        case (size)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        exp_err = (nb == 0);
        if (nb != 0 && (addr % nb) != 0) exp_err = 1'b1;
        if (we && size >= 3'd4) exp_err = 1'b1;
        if ((addr / 4) >= DEPTH) exp_err = 1'b1;
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
                if (size == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (size == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                exp_rdata = v;
            end
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 DUT; lat = -1 on timeout
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] size,
                          output logic [31:0] rdata, output logic err, output int lat);
        rdata = 32'h0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble inputs after acceptance: the DUT must use its captured copy
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
        for (int j = 0; j < 40; j++) begin
            if (rsp_valid) begin
                lat   = j + 1;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 3'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_req_size = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, want 0 0 00000000", rsp_valid, rsp_err, rsp_rdata);
        end
        n_checks++;
        if (req_ready !== 1'b1 || b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b ready0=%b valid0=%b, want 1 1 0", req_ready, b_req_ready, b_rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic        er;
        int          lat;
        vec_t tbl [20] = '{
            '{1'b1, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,        1'b0},
            '{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 1'b0},
            '{1'b1, 32'h13,   32'h7F,       3'd0, 32'h0,        1'b0},
            '{1'b0, 32'h13,   32'h0,        3'd0, 32'h0000007F, 1'b0},
            '{1'b0, 32'h10,   32'h0,        3'd2, 32'h7FADBEEF, 1'b0},
            '{1'b1, 32'h12,   32'h80,       3'd0, 32'h0,        1'b0},
            '{1'b0, 32'h12,   32'h0,        3'd0, 32'hFFFFFF80, 1'b0},
            '{1'b0, 32'h12,   32'h0,        3'd4, 32'h00000080, 1'b0},
            '{1'b1, 32'h11,   32'h1234,     3'd1, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'd2, 32'h7F80BEEF, 1'b0},
            '{1'b0, 32'h1000, 32'h0,        3'd2, 32'h0,        1'b1},
            '{1'b1, 32'hFFC,  32'h13579BDF, 3'd2, 32'h0,        1'b0},
            '{1'b0, 32'hFFC,  32'h0,        3'd2, 32'h13579BDF, 1'b0},
            '{1'b0, 32'h12,   32'h0,        3'd1, 32'h00007F80, 1'b0},
            '{1'b0, 32'h10,   32'h0,        3'd1, 32'hFFFFBEEF, 1'b0},
            '{1'b0, 32'h10,   32'h0,        3'd5, 32'h0000BEEF, 1'b0},
            '{1'b0, 32'h12,   32'h0,        3'd2, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'd3, 32'h0,        1'b1},
            '{1'b1, 32'h10,   32'h55,       3'd4, 32'h0,        1'b1},
            '{1'b0, 32'h10,   32'h0,        3'd2, 32'h7F80BEEF, 1'b0}
        };
        for (int i = 0; i < 20; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, rd, er, lat);
            n_checks++;
            if (lat !== WC + 1) begin
                n_fail++;
                $display("FAIL directed_lat[%0d]: latency=%0d, want %0d", i, lat, WC + 1);
            end
            n_checks++;
            if (rd !== tbl[i].rd || er !== tbl[i].err) begin
                n_fail++;
                $display("FAIL directed_rsp[%0d]: rdata=%h err=%b, want %h %b", i, rd, er, tbl[i].rd, tbl[i].err);
            end
        end
    endtask

    // Response fields hold after the single-cycle rsp_valid pulse
    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h7F80BEEF || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b rdata=%h err=%b, want 0 7f80beef 0", i, rsp_valid, rsp_rdata, rsp_err);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          pulses;
        do_req(1'b1, 32'h20, 32'hAAAAAAAA, 3'd2, rd, er, lat);
        n_checks++;
        if (lat !== WC + 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_first: latency=%0d err=%b, want %0d 0", lat, er, WC + 1);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55555555; req_size = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0;
        if (rsp_valid) pulses++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_async: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rstwait_pulses: rsp_valid pulses=%0d, want 0", pulses);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_cleared: rdata=%h err=%b, want 00000000 0", rsp_rdata, rsp_err);
        end
        do_req(1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'hAAAAAAAA || er !== 1'b0 || lat !== WC + 1) begin
            n_fail++;
            $display("FAIL rstwait_readback: rdata=%h err=%b lat=%0d, want aaaaaaaa 0 %0d", rd, er, lat, WC + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic        prev_ready;
        logic [31:0] last_wd;
        int          accepts, rsps;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h40; b_req_size = 3'd2;
        prev_ready = 1'b0;
        last_wd = 32'h0;
        accepts = 0;
        rsps = 0;
        for (int i = 0; i < 24; i++) begin
            b_req_wdata = $urandom;
            #1;
            if (b_rsp_valid) rsps++;
            if (i > 0) begin
                n_checks++;
                if (b_req_ready === prev_ready) begin
                    n_fail++;
                    $display("FAIL b2b_toggle[%0d]: ready=%b, want %b", i, b_req_ready, !prev_ready);
                end
                n_checks++;
                if (b_rsp_valid !== prev_ready) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: rsp_valid=%b, want %b", i, b_rsp_valid, prev_ready);
                end
            end
            if (b_req_ready) begin
                accepts++;
                last_wd = b_req_wdata;
            end
            prev_ready = b_req_ready;
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        if (b_rsp_valid) rsps++;
        n_checks++;
        if (accepts !== 12 || rsps !== 12) begin
            n_fail++;
            $display("FAIL b2b_counts: accepts=%0d responses=%0d, want 12 12", accepts, rsps);
        end
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h40; b_req_size = 3'd2;
        for (int k = 0; k < 10 && !b_req_ready; k++) @(negedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        n_checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== last_wd || b_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_readback: valid=%b rdata=%h err=%b, want 1 %h 0", b_rsp_valid, b_rsp_rdata, b_rsp_err, last_wd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, wd;
        logic        er, exp_er, we;
        logic [2:0]  sz;
        int          lat;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model_op(1'b1, 32'(w*4), wd, 3'd2, exp_rd, exp_er);
            do_req(1'b1, 32'(w*4), wd, 3'd2, rd, er, lat);
            n_checks++;
            if (er !== exp_er || lat !== WC + 1) begin
                n_fail++;
                $display("FAIL rand_init[%0d]: err=%b lat=%0d, want %b %0d", w, er, lat, exp_er, WC + 1);
            end
        end
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = 32'h1000 + $urandom_range(0, 32'hFFFF);
            else                           addr = $urandom_range(0, 255);
            wd = $urandom;
            model_op(we, addr, wd, sz, exp_rd, exp_er);
            do_req(we, addr, wd, sz, rd, er, lat);
            n_checks++;
            if (lat !== WC + 1) begin
                n_fail++;
                $display("FAIL rand_lat[%0d]: latency=%0d, want %0d", n, lat, WC + 1);
            end
            n_checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: we=%b addr=%h size=%0d rdata=%h err=%b, want %h %b",
                         n, we, addr, sz, rd, er, exp_rd, exp_er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_wait();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
